// File: rtl/snoop_fifo_pkg.sv
// Shared types and index helpers for the parametrised snoopable FIFO.
// Index arithmetic wraps explicitly at DEPTH, so non-power-of-2 depths work.
package snoop_fifo_pkg;

    localparam int unsigned MAX_AW = 16;

    // Response register; fields are sized for the largest supported depth.
    typedef struct packed {
        logic              valid;
        logic              match;
        logic [MAX_AW-1:0] age;
        logic [MAX_AW:0]   hits;
    } snoop_resp_t;

    function automatic int unsigned next_idx(input int unsigned idx, input int unsigned depth);
        if (idx == depth - 1)
            return 0;
        return idx + 1;
    endfunction

    function automatic int unsigned age(input int unsigned idx, input int unsigned rd_idx,
                                        input int unsigned depth);
        if (idx >= rd_idx)
            return idx - rd_idx;
        return idx + depth - rd_idx;
    endfunction

endpackage

// File: rtl/snoop_fifo_match.sv
// Combinational key matcher: oldest matching age relative to the head and a hit count.
module snoop_fifo_match
    import snoop_fifo_pkg::*;
#(
    parameter int unsigned DEPTH = 48,
    parameter int unsigned KEY_W = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0][KEY_W-1:0] keys,
    input  logic [DEPTH-1:0]            occ,
    input  logic [KEY_W-1:0]            key,
    input  logic [AW-1:0]               rd_idx,
    output logic                        match,
    output logic [AW-1:0]               oldest_age,
    output logic [AW:0]                 hits
);

    logic [AW-1:0] entry_age;

    always_comb begin
        match      = 1'b0;
        oldest_age = '0;
        hits       = '0;
        entry_age  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (occ[i] && keys[i] == key) begin
                entry_age = AW'(age(i, 32'(rd_idx), DEPTH));
                if (!match || entry_age < oldest_age)
                    oldest_age = entry_age;
                match = 1'b1;
                hits  = hits + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/snoop_fifo_param.sv
// Parametrised first-word-fall-through FIFO with a registered key snoop port.
// Define SNOOP_FIFO_WR_BYPASS_EN to make a same-cycle push visible to the snoop.
module snoop_fifo_param
    import snoop_fifo_pkg::*;
#(
    parameter int unsigned WIDTH   = 64,
    parameter int unsigned DEPTH   = 48,
    parameter int unsigned KEY_W   = 16,
    parameter int unsigned KEY_LSB = 0,
    parameter int unsigned AW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] wdata,
    input  logic             wvalid,
    output logic             wready,
    output logic [WIDTH-1:0] rdata,
    output logic             rvalid,
    input  logic             rready,
    input  logic [KEY_W-1:0] sdata,
    input  logic             svalid,
    output logic             sresp_valid,
    output logic             smatch,
    output logic [AW-1:0]    sage,
    output logic [AW:0]      shits,
    output logic [AW:0]      count
);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [DEPTH-1:0][KEY_W-1:0] keys;
    logic [DEPTH-1:0]            occ;
    logic [AW-1:0]               wr_idx;
    logic [AW-1:0]               rd_idx;
    logic                        push;
    logic                        pop;
    logic                        m_match;
    logic [AW-1:0]               m_age;
    logic [AW:0]                 m_hits;
    snoop_resp_t                 resp_d;
    snoop_resp_t                 resp_q;

    assign wready = (count != (AW+1)'(DEPTH));
    assign rvalid = (count != '0);
    assign push   = wvalid & wready;
    assign pop    = rvalid & rready;
    assign rdata  = mem[rd_idx];

    always_comb begin
        keys = '0;
        for (int unsigned i = 0; i < DEPTH; i++)
            keys[i] = mem[i][KEY_LSB +: KEY_W];
    end

    snoop_fifo_match #(
        .DEPTH (DEPTH),
        .KEY_W (KEY_W),
        .AW    (AW)
    ) u_match (
        .keys       (keys),
        .occ        (occ),
        .key        (sdata),
        .rd_idx     (rd_idx),
        .match      (m_match),
        .oldest_age (m_age),
        .hits       (m_hits)
    );

    always_comb begin
        resp_d = '0;
        if (svalid) begin
            resp_d.valid = 1'b1;
            resp_d.match = m_match;
            resp_d.age   = MAX_AW'(m_age);
            resp_d.hits  = (MAX_AW+1)'(m_hits);
`ifdef SNOOP_FIFO_WR_BYPASS_EN
            // The in-flight write sits at the tail, so it only sets the age when nothing stored hit.
            if (push && wdata[KEY_LSB +: KEY_W] == sdata) begin
                resp_d.match = 1'b1;
                resp_d.hits  = resp_d.hits + (MAX_AW+1)'(1);
                if (!m_match)
                    resp_d.age = MAX_AW'(count);
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem    <= '0;
            occ    <= '0;
            wr_idx <= '0;
            rd_idx <= '0;
            count  <= '0;
            resp_q <= '0;
        end else begin
            // Push and pop never target the same slot: indices only coincide when empty or full.
            if (push) begin
                mem[wr_idx] <= wdata;
                occ[wr_idx] <= 1'b1;
                wr_idx      <= AW'(next_idx(32'(wr_idx), DEPTH));
            end
            if (pop) begin
                occ[rd_idx] <= 1'b0;
                rd_idx      <= AW'(next_idx(32'(rd_idx), DEPTH));
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            resp_q <= resp_d;
        end
    end

    assign sresp_valid = resp_q.valid;
    assign smatch      = resp_q.match;
    assign sage        = resp_q.age[AW-1:0];
    assign shits       = resp_q.hits[AW:0];

endmodule

// File: tb/tb_snoop_fifo_param.sv
// Scoreboard bench for snoop_fifo_param: FIFO order, full/empty edges, wrap, snoop and async reset.
module tb_snoop_fifo_param;

    localparam int DEPTH = 48;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] wdata = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [63:0] rdata;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [15:0] sdata = '0;
    logic        svalid = 1'b0;
    logic        sresp_valid;
    logic        smatch;
    logic [5:0]  sage;
    logic [6:0]  shits;
    logic [6:0]  count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit v;
        bit m;
        int age;
        int hits;
    } exp_snp_t;

    logic [63:0] model[$];
    exp_snp_t    snp_q[$];

    snoop_fifo_param #(
        .WIDTH   (64),
        .DEPTH   (48),
        .KEY_W   (16),
        .KEY_LSB (0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wdata       (wdata),
        .wvalid      (wvalid),
        .wready      (wready),
        .rdata       (rdata),
        .rvalid      (rvalid),
        .rready      (rready),
        .sdata       (sdata),
        .svalid      (svalid),
        .sresp_valid (sresp_valid),
        .smatch      (smatch),
        .sage        (sage),
        .shits       (shits),
        .count       (count)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference snoop result from the ordered model (index = age).
    function automatic exp_snp_t model_snoop(input logic [15:0] key, input bit wr, input logic [63:0] wd);
        exp_snp_t r;
        r.v = 1'b1; r.m = 1'b0; r.age = 0; r.hits = 0;
        foreach (model[i]) begin
            if (model[i][15:0] == key) begin
                if (!r.m) r.age = i;
                r.m = 1'b1;
                r.hits++;
            end
        end
`ifdef SNOOP_FIFO_WR_BYPASS_EN
        if (wr && wd[15:0] == key) begin
            if (!r.m) r.age = model.size();
            r.m = 1'b1;
            r.hits++;
        end
`else
        if (wr && wd[15:0] == key) r.v = 1'b1;
`endif
        return r;
    endfunction

    task automatic check_snoop(input string name);
        exp_snp_t e;
        if (snp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL %s: got response want queued expectation", name);
            return;
        end
        e = snp_q.pop_front();
        total++;
        if (sresp_valid !== e.v || smatch !== e.m || sage !== 6'(e.age) || shits !== 7'(e.hits)) begin
            bad++;
            $display("FAIL %s: got v=%0b m=%0b age=%0d hits=%0d want v=%0b m=%0b age=%0d hits=%0d",
                     name, sresp_valid, smatch, sage, shits, e.v, e.m, e.age, e.hits);
        end
    endtask

    task automatic test_reset();
        #1;
        total++;
        if (count !== 7'd0 || rvalid !== 1'b0 || wready !== 1'b1 || rdata !== 64'd0 ||
            sresp_valid !== 1'b0 || smatch !== 1'b0 || sage !== 6'd0 || shits !== 7'd0) begin
            bad++;
            $display("FAIL reset_state: got cnt=%0d rv=%0b wr=%0b rd=%0h sv=%0b sm=%0b sa=%0d sh=%0d want all idle",
                     count, rvalid, wready, rdata, sresp_valid, smatch, sage, shits);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_fill_drain();
        logic [63:0] exp;
        wvalid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            wdata = 64'(i);
            tick();
            model.push_back(64'(i));
        end
        total++;
        if (count !== 7'd48 || wready !== 1'b0) begin
            bad++;
            $display("FAIL full_state: got cnt=%0d wready=%0b want cnt=48 wready=0", count, wready);
        end
        wdata = 64'd99;
        tick();
        total++;
        if (count !== 7'd48) begin
            bad++;
            $display("FAIL full_refuse: got cnt=%0d want 48", count);
        end
        // write while full plus pop: write refused, count drops
        rready = 1'b1;
        exp = model.pop_front();
        total++;
        if (rdata !== exp) begin
            bad++;
            $display("FAIL full_pop_data: got %0h want %0h", rdata, exp);
        end
        tick();
        wvalid = 1'b0;
        total++;
        if (count !== 7'd47) begin
            bad++;
            $display("FAIL full_push_pop: got cnt=%0d want 47", count);
        end
        while (model.size() > 0) begin
            exp = model.pop_front();
            total++;
            if (rvalid !== 1'b1 || rdata !== exp) begin
                bad++;
                $display("FAIL drain_data: got rv=%0b data=%0h want rv=1 data=%0h", rvalid, rdata, exp);
            end
            tick();
        end
        total++;
        if (rvalid !== 1'b0 || count !== 7'd0) begin
            bad++;
            $display("FAIL drain_empty: got rv=%0b cnt=%0d want rv=0 cnt=0", rvalid, count);
        end
        tick();
        total++;
        if (count !== 7'd0 || wready !== 1'b1) begin
            bad++;
            $display("FAIL empty_pop_ignored: got cnt=%0d wready=%0b want 0 1", count, wready);
        end
        rready = 1'b0;
    endtask

    task automatic test_wrap();
        logic [63:0] exp;
        wvalid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            wdata = 64'(100 + i);
            tick();
            model.push_back(64'(100 + i));
        end
        wvalid = 1'b0;
        rready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            exp = model.pop_front();
            total++;
            if (rdata !== exp) begin
                bad++;
                $display("FAIL wrap_pop1: got %0h want %0h", rdata, exp);
            end
            tick();
        end
        rready = 1'b0;
        wvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            wdata = 64'(200 + i);
            tick();
            model.push_back(64'(200 + i));
        end
        // simultaneous push and pop: occupancy unchanged
        wdata = 64'd300;
        rready = 1'b1;
        exp = model.pop_front();
        total++;
        if (rdata !== exp) begin
            bad++;
            $display("FAIL wrap_pp_data: got %0h want %0h", rdata, exp);
        end
        tick();
        model.push_back(64'd300);
        wvalid = 1'b0;
        total++;
        if (count !== 7'd20) begin
            bad++;
            $display("FAIL push_pop_count: got %0d want 20", count);
        end
        while (model.size() > 0) begin
            exp = model.pop_front();
            total++;
            if (rdata !== exp) begin
                bad++;
                $display("FAIL wrap_pop2: got %0h want %0h", rdata, exp);
            end
            tick();
        end
        rready = 1'b0;
    endtask

    task automatic test_snoop();
        logic [15:0] ks [3] = '{16'd5, 16'd9, 16'd5};
        wvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wdata = {48'(i + 1), ks[i]};
            tick();
            model.push_back({48'(i + 1), ks[i]});
        end
        wvalid = 1'b0;
        svalid = 1'b1;
        sdata  = 16'd5;
        snp_q.push_back(model_snoop(sdata, 1'b0, '0));
        tick();
        check_snoop("snoop_hit5");
        total++;
        if (smatch !== 1'b1 || sage !== 6'd0 || shits !== 7'd2) begin
            bad++;
            $display("FAIL snoop_hit5_const: got m=%0b age=%0d hits=%0d want 1 0 2", smatch, sage, shits);
        end
        sdata = 16'd7;
        snp_q.push_back(model_snoop(sdata, 1'b0, '0));
        tick();
        check_snoop("snoop_miss7");
        svalid = 1'b0;
        tick();
        total++;
        if (sresp_valid !== 1'b0 || smatch !== 1'b0 || sage !== 6'd0 || shits !== 7'd0 || count !== 7'd3) begin
            bad++;
            $display("FAIL snoop_idle: got v=%0b m=%0b age=%0d hits=%0d cnt=%0d want 0 0 0 0 3",
                     sresp_valid, smatch, sage, shits, count);
        end
    endtask

    task automatic test_snoop_pop();
        logic [63:0] exp;
        svalid = 1'b1;
        sdata  = 16'd5;
        rready = 1'b1;
        snp_q.push_back(model_snoop(sdata, 1'b0, '0));
        exp = model.pop_front();
        total++;
        if (rdata !== exp) begin
            bad++;
            $display("FAIL snoop_pop_data: got %0h want %0h", rdata, exp);
        end
        tick();
        rready = 1'b0;
        check_snoop("snoop_during_pop");
        snp_q.push_back(model_snoop(sdata, 1'b0, '0));
        tick();
        check_snoop("snoop_after_pop");
        total++;
        if (sage !== 6'd1 || shits !== 7'd1) begin
            bad++;
            $display("FAIL snoop_after_pop_const: got age=%0d hits=%0d want 1 1", sage, shits);
        end
        svalid = 1'b0;
    endtask

    task automatic test_snoop_push();
        svalid = 1'b1;
        sdata  = 16'd3;
        wvalid = 1'b1;
        wdata  = {48'hBEEF, 16'd3};
        snp_q.push_back(model_snoop(sdata, 1'b1, wdata));
        tick();
        model.push_back({48'hBEEF, 16'd3});
        wvalid = 1'b0;
        check_snoop("snoop_with_push");
        snp_q.push_back(model_snoop(sdata, 1'b0, '0));
        tick();
        check_snoop("snoop_after_push");
        svalid = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        wvalid = 1'b1;
        while (model.size() < 17) begin
            wdata = 64'(1000 + model.size());
            tick();
            model.push_back(64'(1000 + model.size()));
        end
        wvalid = 1'b0;
        total++;
        if (count !== 7'd17) begin
            bad++;
            $display("FAIL pre_reset_count: got %0d want 17", count);
        end
        svalid = 1'b1;
        sdata  = 16'd9;
        snp_q.push_back(model_snoop(sdata, 1'b0, '0));
        tick();
        check_snoop("snoop_before_reset");
        #2 rst = 1'b1;
        #1;
        total++;
        if (count !== 7'd0 || rvalid !== 1'b0 || wready !== 1'b1 || rdata !== 64'd0 ||
            sresp_valid !== 1'b0 || smatch !== 1'b0 || shits !== 7'd0) begin
            bad++;
            $display("FAIL async_reset: got cnt=%0d rv=%0b wr=%0b rd=%0h sv=%0b sm=%0b sh=%0d want idle",
                     count, rvalid, wready, rdata, sresp_valid, smatch, shits);
        end
        tick();
        total++;
        if (sresp_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_no_pulse: got sresp_valid=%0b want 0", sresp_valid);
        end
        #2 rst = 1'b0;
        svalid = 1'b0;
        model.delete();
        snp_q.delete();
        tick();
        wvalid = 1'b1;
        wdata  = 64'hA5A5_0000_0000_1234;
        tick();
        model.push_back(64'hA5A5_0000_0000_1234);
        wvalid = 1'b0;
        rready = 1'b1;
        total++;
        if (rvalid !== 1'b1 || rdata !== model[0] || count !== 7'd1) begin
            bad++;
            $display("FAIL post_reset_push: got rv=%0b data=%0h cnt=%0d want 1 %0h 1",
                     rvalid, rdata, count, model[0]);
        end
        tick();
        void'(model.pop_front());
        rready = 1'b0;
        total++;
        if (rvalid !== 1'b0 || count !== 7'd0) begin
            bad++;
            $display("FAIL post_reset_pop: got rv=%0b cnt=%0d want 0 0", rvalid, count);
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_wrap();
        test_snoop();
        test_snoop_pop();
        test_snoop_push();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/snoop_fifo_param.md
Name: snoop_fifo_param

Overview:
Parametrised successor to the fixed 64-bit × 48-entry snoopable FIFO. It is a first-word-fall-through valid/ready FIFO for any width and any depth, including non-power-of-2 depths. It adds a key-field snoop port that returns a registered hit flag, the hit's age relative to the head, and a hit count. It sits between request producers and a downstream consumer so hazard logic can check for pending entries with a given key.

Parameters:
WIDTH, 64, entry width in bits
DEPTH, 48, entry count; any value ≥ 2
KEY_W, 16, snoop key width; KEY_LSB+KEY_W ≤ WIDTH
KEY_LSB, 0, bit position of the key field inside an entry
AW, $clog2(DEPTH), index width (derived; do not override)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset; asynchronous and active-high
wdata  in  WIDTH  write data
wvalid  in  1  write request
wready  out  1  FIFO can accept a write (not full)
rdata  out  WIDTH  head entry
rvalid  out  1  FIFO not empty
rready  in  1  consumer pops head
sdata  in  KEY_W  snoop key
svalid  in  1  snoop request
sresp_valid  out  1  snoop result valid; one cycle after svalid
smatch  out  1  at least one occupied entry matched
sage  out  AW  age of the oldest matching entry (0 = head); 0 when no match
shits  out  AW+1  number of occupied entries that matched
count  out  AW+1  current occupancy, 0..DEPTH

Behaviour:
- Reset (async, rst=1):
  - wr_idx=0, rd_idx=0, count=0.
  - All storage cleared to 0.
  - rvalid=0, wready=1, rdata=0.
  - sresp_valid=0, smatch=0, sage=0, shits=0.
  - Asserting rst mid-operation discards all entries and cancels any pending snoop result.
- Indices wrap explicitly: DEPTH-1 → 0. No power-of-2 assumption; no MSB-toggle trick.
- Occupancy is tracked by the count register plus a per-entry occupied bit.
- Handshakes and status:
  - push = wvalid & wready. pop = rvalid & rready.
  - wready = (count != DEPTH). rvalid = (count != 0). Both are derived combinationally from registers.
  - rdata = mem[rd_idx] combinationally (FWFT); it holds stale data when rvalid=0.
- Full: a write is refused even if a pop occurs the same cycle. There is no pass-through write while full.
- Empty: rready is ignored and indices do not move.
- Simultaneous push and pop while not full and not empty: count unchanged; both indices advance.
- Snoop:
  - When svalid=1 in cycle N, the key is compared against mem[i][KEY_LSB+:KEY_W] for every occupied i. Compare uses the cycle-N register state, before that cycle's push/pop.
  - An entry popped in cycle N is still eligible. An entry pushed in cycle N is not (see Optional Feature).
  - Results are registered and presented in cycle N+1 with sresp_valid=1; latency is exactly 1.
  - sage = (i - rd_idx) mod DEPTH for the smallest such age among matching entries.
  - shits = population count of matches.
  - When svalid=0, next cycle sresp_valid=0 and smatch/sage/shits return to 0.
- Back-to-back snoops every cycle are supported; throughput is 1 per cycle.
- Snoop never stalls or alters the FIFO.

Optional Feature:
Macro SNOOP_FIFO_WR_BYPASS_EN.
- Defined: a push occurring in snoop cycle N is also compared (wdata key).
  - A hit sets smatch.
  - It counts toward shits.
  - It yields sage = count(N) only if no stored entry matched.
- Undefined: in-flight writes are invisible to snoop; behaviour is as in Behaviour.

Decomposition:
- Package snoop_fifo_pkg holds:
  - the index-wrap function: next_idx(idx, DEPTH);
  - the age function: age(idx, rd_idx, DEPTH);
  - the response struct typedef {valid, match, age, hits}.
- One sub-module is natural: snoop_fifo_match. It is combinational; it takes the storage vector, occupied bits, key and rd_idx, and produces the oldest-age priority select and the popcount.
- The top level owns storage, indices, count and the response register.

Test Plan:
- Reset then 48 pushes of 0..47 with rready=0 → count=48, wready=0. A 49th push is refused. Pops return 0..47 in order; rvalid drops after the last.
- DEPTH=48 wrap: push 40, pop 40, push 20 → rd_idx=40, wr_idx=12. Popped data is in order across the 47→0 boundary.
- Store keys {5,9,5} at ages 0..2. Snoop 5 → next cycle sresp_valid=1, smatch=1, sage=0, shits=2. Snoop 7 → smatch=0, shits=0.
- Snoop key 5 in the same cycle the age-0 entry 5 pops → smatch=1, sage=0, shits=2. Snoop 5 in the following cycle → sage=1, shits=1.
- Snoop in the same cycle as a push of key 3 → smatch=0 without SNOOP_FIFO_WR_BYPASS_EN; smatch=1, sage=count with it.
- Assert rst asynchronously mid-stream, with a snoop pending and count=17 → outputs go to reset values immediately, with no sresp_valid pulse. After rst deasserts, first push/pop works from index 0.
